vga_vram_arbiter: RTL and testbench

- Shares the single-port video RAM between two requesters: pixel writes from the CPU `VGA` instruction and pixel reads from the VGA scan-out controller.
- Display reads always win.
- CPU writes are buffered in a small FIFO and drained in idle slots.
- Also sequences a full-screen clear on request.
- Sits between the CPU execute stage, the VGA timing controller and the VRAM.

---
 rtl/vga_vram_arbiter_if.sv | 50 +++++
 rtl/vga_vram_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_vga_vram_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter and its neighbours: CPU pixel writes, display reads,
// clear control and the single-port VRAM. The slave modport is the arbiter's view.
interface vga_vram_arbiter_if #(
    parameter int COL_BITS   = 8,
    parameter int ROW_BITS   = 7,
    parameter int COLOR_BITS = 3
);
    logic                         wr_req;
    logic [COL_BITS-1:0]          wr_col;
    logic [ROW_BITS-1:0]          wr_row;
    logic [COLOR_BITS-1:0]        wr_color;
    logic                         wr_full;
    logic                         overflow;

    logic                         rd_req;
    logic [COL_BITS+ROW_BITS-1:0] rd_addr;
    logic [COLOR_BITS-1:0]        rd_data;
    logic                         rd_valid;

    logic                         clear;
    logic [COLOR_BITS-1:0]        clear_color;
    logic                         clear_busy;

    logic [COL_BITS+ROW_BITS-1:0] ram_addr;
    logic                         ram_we;
    logic [COLOR_BITS-1:0]        ram_data;
    logic [COLOR_BITS-1:0]        ram_rdata;

    modport master (
        output wr_req, wr_col, wr_row, wr_color,
        input  wr_full, overflow,
        output rd_req, rd_addr,
        input  rd_data, rd_valid,
        output clear, clear_color,
        input  clear_busy,
        input  ram_addr, ram_we, ram_data,
        output ram_rdata
    );

    modport slave (
        input  wr_req, wr_col, wr_row, wr_color,
        output wr_full, overflow,
        input  rd_req, rd_addr,
        output rd_data, rd_valid,
        input  clear, clear_color,
        output clear_busy,
        output ram_addr, ram_we, ram_data,
        input  ram_rdata
    );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display reads first, then full-screen clear, then buffered CPU writes.
// Define VRAM_ARB_STARVE_GUARD_EN to force a write slot after STARVE_LIMIT back-to-back read grants.
module vga_vram_arbiter #(
    parameter int COL_BITS     = 8,
    parameter int ROW_BITS     = 7,
    parameter int COLOR_BITS   = 3,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 16
) (
    input logic               clk,
    input logic               rst,
    vga_vram_arbiter_if.slave bus
);
    localparam int ADDR_BITS = COL_BITS + ROW_BITS;
    localparam int PTR_BITS  = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS  = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
        $error("vga_vram_arbiter: FIFO_DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
    end

    typedef enum logic {
        IDLE,
        CLEAR
    } clear_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_READ,
        GRANT_CLEAR,
        GRANT_FIFO
    } grant_t;

    logic [ADDR_BITS-1:0]  fifo_addr  [FIFO_DEPTH];
    logic [COLOR_BITS-1:0] fifo_color [FIFO_DEPTH];
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [CNT_BITS-1:0]   count;
    logic [CNT_BITS-1:0]   count_next;
    logic                  full_q;
    logic                  overflow_q;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;

    clear_state_t          state;
    logic [ADDR_BITS-1:0]  clear_ptr;
    logic [COLOR_BITS-1:0] clear_color_q;
    logic                  busy_q;

    logic [ADDR_BITS-1:0]  ram_addr_q;
    logic                  ram_we_q;
    logic [COLOR_BITS-1:0] ram_data_q;
    logic                  rd_inflight;
    logic                  rd_valid_q;

    grant_t                grant;
    logic                  write_pending;
    logic                  force_write;

    assign fifo_empty    = (count == '0);
    assign write_pending = (state == CLEAR) || !fifo_empty;

    // Admission uses the start-of-cycle full flag, so a same-cycle pop never lets a write in.
    assign push = bus.wr_req && !full_q;
    assign pop  = (grant == GRANT_FIFO);

    always_comb begin
        grant = GRANT_NONE;
        if (bus.rd_req && !force_write) begin
            grant = GRANT_READ;
        end else if (state == CLEAR) begin
            grant = GRANT_CLEAR;
        end else if (!fifo_empty) begin
            grant = GRANT_FIFO;
        end
    end

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int STARVE_BITS = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_BITS-1:0] starve_cnt;

    assign force_write = write_pending && (starve_cnt == STARVE_BITS'(STARVE_LIMIT));

    // Counts read grants that happened while a write was waiting; any write grant restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!write_pending || grant != GRANT_READ) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign force_write = 1'b0;
`endif

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= {bus.wr_row, bus.wr_col};
            fifo_color[wr_ptr] <= bus.wr_color;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (bus.wr_req && full_q) begin
                overflow_q <= 1'b1;
            end
            count  <= count_next;
            full_q <= (count_next == CNT_BITS'(FIFO_DEPTH));
        end
    end

    // Clear sequencer plus the registered VRAM command and the two-stage read-valid pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            clear_ptr     <= '0;
            clear_color_q <= '0;
            busy_q        <= 1'b0;
            ram_addr_q    <= '0;
            ram_we_q      <= 1'b0;
            ram_data_q    <= '0;
            rd_inflight   <= 1'b0;
            rd_valid_q    <= 1'b0;
        end else begin
            rd_inflight <= (grant == GRANT_READ);
            rd_valid_q  <= rd_inflight;
            ram_we_q    <= 1'b0;

            unique case (grant)
                GRANT_READ: begin
                    ram_addr_q <= bus.rd_addr;
                end
                GRANT_CLEAR: begin
                    ram_addr_q <= clear_ptr;
                    ram_data_q <= clear_color_q;
                    ram_we_q   <= 1'b1;
                end
                GRANT_FIFO: begin
                    ram_addr_q <= fifo_addr[rd_ptr];
                    ram_data_q <= fifo_color[rd_ptr];
                    ram_we_q   <= 1'b1;
                end
                default: begin
                end
            endcase

            unique case (state)
                IDLE: begin
                    if (bus.clear) begin
                        state         <= CLEAR;
                        clear_ptr     <= '0;
                        clear_color_q <= bus.clear_color;
                        busy_q        <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (grant == GRANT_CLEAR) begin
                        clear_ptr <= clear_ptr + 1'b1;
                        if (&clear_ptr) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.wr_full    = full_q;
    assign bus.overflow   = overflow_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = bus.ram_rdata;
    assign bus.clear_busy = busy_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_data   = ram_data_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Self-checking bench for vga_vram_arbiter: directed scenarios then random traffic, all checked
// every cycle against a queue-based model of the arbitration rules and a behavioural VRAM.
module tb_vga_vram_arbiter;
    localparam int COL_BITS     = 3;
    localparam int ROW_BITS     = 2;
    localparam int COLOR_BITS   = 3;
    localparam int FIFO_DEPTH   = 4;
    localparam int STARVE_LIMIT = 16;
    localparam int AW           = COL_BITS + ROW_BITS;
    localparam int NPIX         = 1 << AW;

    bit clk;
    bit rst;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    vga_vram_arbiter_if #(.COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS), .COLOR_BITS(COLOR_BITS)) vif ();

    vga_vram_arbiter #(
        .COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS), .COLOR_BITS(COLOR_BITS),
        .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(vif.slave)
    );

    always #5 clk = ~clk;

    // Behavioural single-port VRAM with one cycle read latency, preloaded on its first clock.
    logic [COLOR_BITS-1:0] vram [NPIX];
    bit ramLoaded;
    always @(posedge clk) begin
        if (!ramLoaded) begin
            for (int i = 0; i < NPIX; i++) vram[i] <= COLOR_BITS'(i * 5 + 3);
            ramLoaded <= 1'b1;
        end else if (vif.ram_we) begin
            vram[vif.ram_addr] <= vif.ram_data;
        end
        vif.ram_rdata <= vram[vif.ram_addr];
    end

    // Stimulus for the next cycle
    bit sWr, sRd, sClr;
    int sCol, sRow, sColor, sRdAddr, sClrColor;

    // Reference model state
    int  qAddr[$];
    int  qColor[$];
    int  mMem [NPIX];
    bit  mClearing, mOverflow, mFull, mP1Valid;
    int  mClearPtr, mClearColor, mP1Data, mStarve;
    bit  eWe, eRdValid, eBusy;
    int  eAddr, eData, eRdData;

    task automatic writePixel(input int a, input int c);
        eWe = 1; eAddr = a; eData = c; mMem[a] = c;
    endtask

    // One cycle of the arbitration rules, producing what should be visible after the next edge.
    task automatic modelStep();
        bit pending, forceWr, readGr, wasClearing, fullAtStart;
        if (rst) begin
            qAddr.delete(); qColor.delete();
            mClearing = 0; mOverflow = 0; mFull = 0; mP1Valid = 0; mStarve = 0;
            eWe = 0; eAddr = 0; eData = 0; eRdValid = 0; eBusy = 0;
            return;
        end
        pending     = mClearing || qAddr.size() > 0;
        wasClearing = mClearing;
        fullAtStart = mFull;
`ifdef VRAM_ARB_STARVE_GUARD_EN
        forceWr = pending && mStarve >= STARVE_LIMIT;
`else
        forceWr = 0;
`endif
        eRdValid = mP1Valid;
        eRdData  = mP1Data;
        readGr   = sRd && !forceWr;
        eWe      = 0;
        mP1Valid = 0;
        if (readGr) begin
            eAddr = sRdAddr; mP1Valid = 1; mP1Data = mMem[sRdAddr];
        end else if (mClearing) begin
            writePixel(mClearPtr, mClearColor);
            if (mClearPtr == NPIX - 1) mClearing = 0;
            else mClearPtr++;
        end else if (qAddr.size() > 0) begin
            writePixel(qAddr.pop_front(), qColor.pop_front());
        end
        mStarve = (readGr && pending) ? mStarve + 1 : 0;
        if (sWr) begin
            if (fullAtStart) mOverflow = 1;
            else begin
                qAddr.push_back(((sRow % (1 << ROW_BITS)) * (1 << COL_BITS) + (sCol % (1 << COL_BITS))) % NPIX);
                qColor.push_back(sColor);
            end
        end
        mFull = (qAddr.size() == FIFO_DEPTH);
        if (!wasClearing && sClr) begin
            mClearing = 1; mClearPtr = 0; mClearColor = sClrColor;
        end
        eBusy = mClearing;
    endtask

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkOne("ram_we", 32'(vif.ram_we), 32'(eWe));
        checkOne("ram_addr", 32'(vif.ram_addr), 32'(eAddr));
        if (eWe) checkOne("ram_data", 32'(vif.ram_data), 32'(eData));
        checkOne("wr_full", 32'(vif.wr_full), 32'(mFull));
        checkOne("overflow", 32'(vif.overflow), 32'(mOverflow));
        checkOne("clear_busy", 32'(vif.clear_busy), 32'(eBusy));
        checkOne("rd_valid", 32'(vif.rd_valid), 32'(eRdValid));
        if (eRdValid) checkOne("rd_data", 32'(vif.rd_data), 32'(eRdData));
    endtask

    task automatic applyStimulus();
        vif.wr_req      = sWr;
        vif.wr_col      = COL_BITS'(sCol);
        vif.wr_row      = ROW_BITS'(sRow);
        vif.wr_color    = COLOR_BITS'(sColor);
        vif.rd_req      = sRd;
        vif.rd_addr     = AW'(sRdAddr);
        vif.clear       = sClr;
        vif.clear_color = COLOR_BITS'(sClrColor);
        modelStep();
        @(posedge clk);
        #1;
        cyc++;
        checkOutput();
    endtask

    task automatic quiet();
        rst = 0; sWr = 0; sRd = 0; sClr = 0;
        sCol = 0; sRow = 0; sColor = 0; sRdAddr = 0; sClrColor = 0;
    endtask

    task automatic idle(input int n);
        quiet();
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic doReset();
        quiet(); rst = 1;
        applyStimulus();
        applyStimulus();
        rst = 0;
    endtask

    task automatic randWrite();
        sCol = $urandom_range(0, (1 << COL_BITS) - 1);
        sRow = $urandom_range(0, (1 << ROW_BITS) - 1);
        sColor = $urandom_range(0, (1 << COLOR_BITS) - 1);
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) mMem[i] = (i * 5 + 3) % (1 << COLOR_BITS);
        mP1Data = 0; mClearPtr = 0; mClearColor = 0; eRdData = 0;

        $display("[TB] reset state");
        doReset();

        $display("[TB] single CPU write with display idle");
        quiet(); sWr = 1; sCol = 5; sRow = 3; sColor = 2;
        applyStimulus();
        idle(4);

        $display("[TB] ten reads with three writes queued behind them");
        for (int n = 0; n < 10; n++) begin
            quiet(); sRd = 1; sRdAddr = $urandom_range(0, NPIX - 1);
            if (n < 3) begin sWr = 1; randWrite(); end
            applyStimulus();
        end
        idle(6);
        sRd = 1; sRdAddr = 29;
        applyStimulus();
        idle(3);

        $display("[TB] five writes while reads hold the RAM");
        for (int n = 0; n < 5; n++) begin
            quiet(); sRd = 1; sRdAddr = n; sWr = 1; randWrite();
            applyStimulus();
        end
        idle(8);
        checkOne("overflow_sticky", 32'(vif.overflow), 32'd1);

        $display("[TB] clear with a CPU write pushed mid-clear");
        doReset();
        quiet(); sClr = 1; sClrColor = 1;
        applyStimulus();
        idle(3);
        sWr = 1; sCol = 2; sRow = 1; sColor = 6; sClr = 1; sClrColor = 5;
        applyStimulus();
        idle(NPIX + 4);
        for (int n = 0; n < 4; n++) begin
            quiet(); sRd = 1; sRdAddr = n * 9 % NPIX;
            applyStimulus();
        end
        idle(3);

        $display("[TB] reset in the middle of a clear");
        quiet(); sClr = 1; sClrColor = 4; sWr = 1; randWrite();
        applyStimulus();
        idle(2);
        sRd = 1; sRdAddr = 7;
        applyStimulus();
        quiet(); rst = 1;
        applyStimulus();
        rst = 0;
        idle(4);

        $display("[TB] continuous reads with one pending write");
        quiet(); sWr = 1; sCol = 1; sRow = 2; sColor = 7; sRd = 1; sRdAddr = 3;
        applyStimulus();
        for (int n = 0; n < 22; n++) begin
            quiet(); sRd = 1; sRdAddr = $urandom_range(0, NPIX - 1);
            applyStimulus();
        end
        idle(4);

        $display("[TB] random traffic");
        for (int n = 0; n < 700; n++) begin
            quiet();
            rst       = ($urandom_range(0, 199) == 0);
            sRd       = ($urandom_range(0, 9) < 6);
            sRdAddr   = $urandom_range(0, NPIX - 1);
            sWr       = ($urandom_range(0, 9) < 3);
            randWrite();
            sClr      = ($urandom_range(0, 79) == 0);
            sClrColor = $urandom_range(0, (1 << COLOR_BITS) - 1);
            applyStimulus();
        end
        idle(NPIX + 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
